// File: rtl/ctrl_hub75_defs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_hub75_defs (package)                                  |
// | Description : Shared state encodings and width helper for the HUB75      |
// |               bit-plane (BCM) scan controller.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ctrl_hub75_defs;

  // Scan FSM states, explicitly encoded so waveforms read the same everywhere
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CLK   = 3'd3,
    S_LATCH = 3'd4,
    S_SHOW  = 3'd5,
    S_BLANK = 3'd6
  } state_t;

  // Ceiling log2, usable in parameter elaboration
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_hub75_bcm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_hub75_bcm_if                                          |
// | Description : Pixel-RAM port plus HUB75 panel pins of the BCM scan       |
// |               controller. master = controller, slave = RAM/panel side.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface ctrl_hub75_bcm_if
  import ctrl_hub75_defs::*;
#(
  parameter int COLS = 64,
  parameter int ROWS = 32,
  parameter int BITS = 4
);
  localparam int COL_W = clog2(COLS);
  localparam int ROW_W = clog2(ROWS);

  logic                   init;
  logic [ROW_W+COL_W-1:0] px_addr;
  logic [6*BITS-1:0]      px_data;
  logic                   R0, G0, B0, R1, G1, B1;
  logic                   PX_CLK;
  logic                   LATCH;
  logic                   NOE;
  logic [ROW_W-1:0]       ROW_SEL;
  logic                   frame_done;
  logic                   busy;

  modport master (
    input  init, px_data,
    output px_addr, R0, G0, B0, R1, G1, B1, PX_CLK, LATCH, NOE, ROW_SEL,
           frame_done, busy
  );

  modport slave (
    output init, px_data,
    input  px_addr, R0, G0, B0, R1, G1, B1, PX_CLK, LATCH, NOE, ROW_SEL,
           frame_done, busy
  );

endinterface
`default_nettype wire

// File: rtl/counter_z.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter_z                                                  |
// | Description : Up-counter with synchronous clear, increment enable and a  |
// |               terminal-count flag z (q equals the supplied last value).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module counter_z #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         z
);

  // Count register: clear has priority over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + W'(1);
    end
  end

  assign z = (q == last);

endmodule
`default_nettype wire

// File: rtl/ctrl_hub75_bcm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_hub75_bcm                                             |
// | Description : HUB75 LED panel scan controller using binary-coded         |
// |               modulation: shifts one bit plane per row, latches it and   |
// |               lights it for DELAY_BASE<<bit cycles.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ctrl_hub75_bcm
  import ctrl_hub75_defs::*;
#(
  parameter int COLS       = 64,
  parameter int ROWS       = 32,
  parameter int BITS       = 4,
  parameter int DELAY_BASE = 16
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_hub75_bcm_if.master bus
);

  localparam int COL_W = clog2(COLS);
  localparam int ROW_W = clog2(ROWS);
  localparam int BIT_W = (BITS > 1) ? clog2(BITS) : 1;
  localparam int ON_W  = clog2((DELAY_BASE << (BITS - 1)) + 1);

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(BITS - 1);
  localparam logic [ON_W-1:0]  c_ON_BASE  = ON_W'(DELAY_BASE);

  state_t                 r_state;
  logic [ROW_W+COL_W-1:0] r_px_addr;
  logic [5:0]             r_rgb;
  logic                   r_px_clk;
  logic                   r_latch;
  logic                   r_noe;
  logic [ROW_W-1:0]       r_row_sel;
  logic                   r_frame_done;
  logic                   r_busy;

  logic [COL_W-1:0] w_col_q, w_col_nxt;
  logic [ROW_W-1:0] w_row_q, w_row_nxt;
  logic [BIT_W-1:0] w_bit_q;
  logic [ON_W-1:0]  w_on_q, w_on_last;
  logic             w_col_z, w_row_z, w_bit_z, w_on_z;
  logic             w_col_clr, w_col_inc, w_row_clr, w_row_inc;
  logic             w_bit_clr, w_bit_inc, w_on_clr, w_on_inc;
  logic             w_frame_end;
  logic [5:0]       w_plane;
  logic             w_unused_on;

  // Counter control decode and next col/row values used to form px_addr
  always_comb begin
    w_frame_end = w_bit_z && w_row_z;
    w_col_clr   = (r_state == S_IDLE) || ((r_state == S_CLK) && w_col_z);
    w_col_inc   = (r_state == S_CLK) && !w_col_z;
    w_bit_clr   = (r_state == S_IDLE) || ((r_state == S_BLANK) && w_bit_z);
    w_bit_inc   = (r_state == S_BLANK) && !w_bit_z;
    w_row_clr   = (r_state == S_IDLE) || ((r_state == S_BLANK) && w_frame_end);
    w_row_inc   = (r_state == S_BLANK) && w_bit_z && !w_row_z;
    w_on_clr    = (r_state != S_SHOW);
    w_on_inc    = (r_state == S_SHOW);
    w_on_last   = (c_ON_BASE << w_bit_q) - ON_W'(1);
    w_col_nxt   = w_col_q;
    w_row_nxt   = w_row_q;
    if (w_col_clr)      w_col_nxt = '0;
    else if (w_col_inc) w_col_nxt = w_col_q + COL_W'(1);
    if (w_row_clr)      w_row_nxt = '0;
    else if (w_row_inc) w_row_nxt = w_row_q + ROW_W'(1);
  end

  // On-time is only consumed through its terminal flag
  assign w_unused_on = ^w_on_q;

  counter_z #(.W(COL_W)) u_col (
    .clk(clk), .rst(rst), .clr(w_col_clr), .inc(w_col_inc),
    .last(c_COL_LAST), .q(w_col_q), .z(w_col_z)
  );
  counter_z #(.W(ROW_W)) u_row (
    .clk(clk), .rst(rst), .clr(w_row_clr), .inc(w_row_inc),
    .last(c_ROW_LAST), .q(w_row_q), .z(w_row_z)
  );
  counter_z #(.W(BIT_W)) u_bit (
    .clk(clk), .rst(rst), .clr(w_bit_clr), .inc(w_bit_inc),
    .last(c_BIT_LAST), .q(w_bit_q), .z(w_bit_z)
  );
  counter_z #(.W(ON_W)) u_on (
    .clk(clk), .rst(rst), .clr(w_on_clr), .inc(w_on_inc),
    .last(w_on_last), .q(w_on_q), .z(w_on_z)
  );

  // Pick the current bit plane out of each of the six colour fields
  for (genvar f = 0; f < 6; f++) begin : g_field
    logic [BITS-1:0] w_field;
    assign w_field    = bus.px_data[f*BITS +: BITS];
    assign w_plane[f] = w_field[w_bit_q];
  end

  // Scan FSM; every panel output is registered for the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_px_addr    <= '0;
      r_rgb        <= '0;
      r_px_clk     <= 1'b0;
      r_latch      <= 1'b0;
      r_noe        <= 1'b1;
      r_row_sel    <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_px_clk     <= 1'b0;
      r_latch      <= 1'b0;
      r_noe        <= 1'b1;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.init) begin
            r_state   <= S_FETCH;
            r_busy    <= 1'b1;
            r_px_addr <= {w_row_nxt, w_col_nxt};
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_state  <= S_CLK;
          r_px_clk <= 1'b1;
          r_rgb    <= w_plane;
        end
        S_CLK: begin
          if (w_col_z) begin
            r_state   <= S_LATCH;
            r_latch   <= 1'b1;
            r_row_sel <= w_row_q;
          end else begin
            r_state   <= S_FETCH;
            r_px_addr <= {w_row_nxt, w_col_nxt};
          end
        end
        S_LATCH: begin
          r_state <= S_SHOW;
          r_noe   <= 1'b0;
        end
        S_SHOW: begin
          if (w_on_z) begin
            r_state      <= S_BLANK;
            r_frame_done <= w_frame_end;
          end else begin
            r_noe <= 1'b0;
          end
        end
        S_BLANK: begin
          r_px_addr <= {w_row_nxt, w_col_nxt};
          // Run enable is only honoured at the frame boundary
          if (w_frame_end && !bus.init) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.px_addr    = r_px_addr;
  assign bus.R0         = r_rgb[0];
  assign bus.G0         = r_rgb[1];
  assign bus.B0         = r_rgb[2];
  assign bus.R1         = r_rgb[3];
  assign bus.G1         = r_rgb[4];
  assign bus.B1         = r_rgb[5];
  assign bus.PX_CLK     = r_px_clk;
  assign bus.LATCH      = r_latch;
  assign bus.NOE        = r_noe;
  assign bus.ROW_SEL    = r_row_sel;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_hub75_bcm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ctrl_hub75_bcm                                          |
// | Description : Directed self-checking bench for ctrl_hub75_bcm with       |
// |               COLS=4, ROWS=2, BITS=2, DELAY_BASE=3.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ctrl_hub75_bcm;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   mode     = 0;

  ctrl_hub75_bcm_if #(.COLS(4), .ROWS(2), .BITS(2)) bus ();

  ctrl_hub75_bcm #(.COLS(4), .ROWS(2), .BITS(2), .DELAY_BASE(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel RAM model: one cycle read latency
  function automatic logic [11:0] mem_fn(input logic [2:0] a, input int m);
    if (m == 0) return 12'h0F0;
    return 12'h93A ^ ({9'd0, a} * 12'h2C5);
  endfunction

  always @(posedge clk) bus.px_data <= mem_fn(bus.px_addr, mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bit plane, starting at the negedge just after FETCH of column 0
  task automatic plane(input int r, input int b, input int m, input bit last);
    logic [11:0] d;
    logic [5:0]  exp;
    for (int c = 0; c < 4; c++) begin
      chk("fetch_addr", 32'(bus.px_addr), 32'(r * 4 + c));
      chk("fetch_pxclk", 32'(bus.PX_CLK), 0);
      chk("fetch_noe", 32'(bus.NOE), 1);
      step();
      chk("load_pxclk", 32'(bus.PX_CLK), 0);
      step();
      d = mem_fn(3'(r * 4 + c), m);
      if (m == 0) exp = 6'b001100;
      else exp = {d[10+b], d[8+b], d[6+b], d[4+b], d[2+b], d[b]};
      chk("clk_pxclk", 32'(bus.PX_CLK), 1);
      chk("clk_latch", 32'(bus.LATCH), 0);
      chk("clk_rgb", 32'({bus.B1, bus.G1, bus.R1, bus.B0, bus.G0, bus.R0}), 32'(exp));
      step();
    end
    chk("latch_strobe", 32'(bus.LATCH), 1);
    chk("latch_pxclk", 32'(bus.PX_CLK), 0);
    chk("latch_noe", 32'(bus.NOE), 1);
    chk("latch_rowsel", 32'(bus.ROW_SEL), 32'(r));
    step();
    for (int k = 0; k < (3 << b); k++) begin
      chk("show_noe", 32'(bus.NOE), 0);
      step();
    end
    chk("blank_noe", 32'(bus.NOE), 1);
    chk("blank_frame_done", 32'(bus.frame_done), 32'(last));
    chk("blank_busy", 32'(bus.busy), 1);
    step();
  endtask

  // Continuous invariant and frame-timing monitor
  logic       m_prev_noe  = 1'b1;
  logic       m_prev_busy = 1'b0;
  logic [0:0] m_prev_rs   = '0;
  int         m_run = 0, m_last_run = 6, m_start = 0, m_prev_fd = 0, m_pxcnt = 0;
  bit         m_valid = 0, m_have_prev = 0;

  always @(negedge clk) begin
    if (!rst) begin
      m_run = 0; m_last_run = 6; m_valid = 0; m_have_prev = 0;
      m_prev_noe = 1'b1; m_prev_busy = 1'b0;
    end else begin
      chk("latch_pxclk_overlap", 32'(bus.LATCH & bus.PX_CLK), 0);
      if (!bus.NOE && !m_prev_noe) chk("rowsel_stable", 32'(bus.ROW_SEL), 32'(m_prev_rs));
      if (!bus.NOE) m_run++;
      else if (m_run > 0) begin
        chk("noe_run", 32'(m_run), (m_last_run == 3) ? 6 : 3);
        m_last_run = m_run;
        m_run = 0;
      end
      if (bus.busy && !m_prev_busy) begin
        m_valid = 1; m_start = cyc; m_pxcnt = 0;
      end
      if (!bus.busy) m_have_prev = 0;
      if (bus.PX_CLK) m_pxcnt++;
      if (bus.frame_done) begin
        if (m_valid) begin
          chk("frame_len", 32'(cyc - m_start), 73);
          chk("pxclk_count", 32'(m_pxcnt), 16);
        end
        if (m_have_prev) chk("frame_period", 32'(cyc - m_prev_fd), 74);
        m_have_prev = 1; m_prev_fd = cyc;
        m_valid = 1; m_start = cyc + 1; m_pxcnt = 0;
      end
      m_prev_noe = bus.NOE; m_prev_busy = bus.busy; m_prev_rs = bus.ROW_SEL;
    end
  end

  initial begin
    rst = 1'b0;
    bus.init = 1'b0;
    step();
    step();
    // Reset values
    chk("rst_noe", 32'(bus.NOE), 1);
    chk("rst_rowsel", 32'(bus.ROW_SEL), 0);
    chk("rst_addr", 32'(bus.px_addr), 0);
    chk("rst_rgb", 32'({bus.B1, bus.G1, bus.R1, bus.B0, bus.G0, bus.R0}), 0);
    chk("rst_pxclk", 32'(bus.PX_CLK), 0);
    chk("rst_latch", 32'(bus.LATCH), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // Released with init low: stays idle
    rst = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_noe", 32'(bus.NOE), 1);

    // Frame 1: constant 0x0F0 data, init held high
    bus.init = 1'b1;
    step();
    chk("start_busy", 32'(bus.busy), 1);
    plane(0, 0, 0, 0);
    plane(0, 1, 0, 0);
    plane(1, 0, 0, 0);
    plane(1, 1, 0, 1);

    // Frame 2 follows back to back; init dropped mid-frame
    mode = 1;
    plane(0, 0, 1, 0);
    plane(0, 1, 1, 0);
    bus.init = 1'b0;
    plane(1, 0, 1, 0);
    plane(1, 1, 1, 1);
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_frame_done", 32'(bus.frame_done), 0);
    step();
    chk("idle_hold_busy", 32'(bus.busy), 0);
    chk("idle_hold_noe", 32'(bus.NOE), 1);

    // Frame 3: aborted by reset during row 1 SHOW
    bus.init = 1'b1;
    step();
    plane(0, 0, 1, 0);
    plane(0, 1, 1, 0);
    for (int c = 0; c < 4; c++) begin
      step(); step(); step();
    end
    chk("abort_latch", 32'(bus.LATCH), 1);
    step();
    chk("abort_show_noe", 32'(bus.NOE), 0);
    chk("abort_show_rowsel", 32'(bus.ROW_SEL), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_noe", 32'(bus.NOE), 1);
    chk("async_busy", 32'(bus.busy), 0);
    chk("async_rowsel", 32'(bus.ROW_SEL), 0);
    chk("async_addr", 32'(bus.px_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Restart from row 0, bit 0 and run one full frame
    mode = 0;
    step();
    chk("restart_busy", 32'(bus.busy), 1);
    plane(0, 0, 0, 0);
    plane(0, 1, 0, 0);
    plane(1, 0, 0, 0);
    bus.init = 1'b0;
    plane(1, 1, 0, 1);
    chk("final_busy", 32'(bus.busy), 0);
    chk("final_noe", 32'(bus.NOE), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
